// File: rtl/fc_argmax.sv
// fc_argmax: streaming argmax over packed signed logits arriving on an AXIS slave port.
// Latency: result registers and argmax_done assert 1 cycle after the TLAST handshake.
// Backpressure: TREADY is high only in RUN; it is also gated by M_AXIS_TREADY with ARGMAX_PASSTHRU_EN.
//
// Ports:
//   clk, rstn           single clock, asynchronous active-low reset
//   argmax_start        level run request; argmax_done held until it drops
//   S_AXIS_*            logit stream, lane 0 = TDATA[ELEM_WIDTH-1:0] (lowest class index)
//   max_index/max_value argmax result (32'hFFFF_FFFF / most-negative if nothing competed)
//   elem_count          kept lanes in the frame, saturating at 16'hFFFF
//   overflow_err        sticky: a kept lane sat at positional index >= MAX_CLASSES
//   M_AXIS_*            unchanged forward of the S beats, only when ARGMAX_PASSTHRU_EN is defined
module fc_argmax #(
   parameter int DATA_WIDTH  = 32,
   parameter int ELEM_WIDTH  = 8,
   parameter int MAX_CLASSES = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    argmax_start,
   output logic                    argmax_done,
   output logic                    S_AXIS_TREADY,
   input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
   input  logic                    S_AXIS_TUSER,
   input  logic                    S_AXIS_TLAST,
   input  logic                    S_AXIS_TVALID,
   output logic [31:0]             max_index,
   output logic [ELEM_WIDTH-1:0]   max_value,
   output logic [15:0]             elem_count,
   output logic                    overflow_err
`ifdef ARGMAX_PASSTHRU_EN
   ,
   input  logic                    M_AXIS_TREADY,
   output logic                    M_AXIS_TVALID,
   output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
   output logic                    M_AXIS_TUSER,
   output logic                    M_AXIS_TLAST
`endif
);

   localparam int LANES       = DATA_WIDTH / ELEM_WIDTH;
   localparam int KEEP_STRIDE = ELEM_WIDTH / 8;
   localparam int KW          = $clog2(LANES + 1);
   localparam logic [ELEM_WIDTH-1:0] MOST_NEG = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t state, state_nxt;
   logic   run;
   logic   accept;

   // Running values for the frame in progress.
   logic [ELEM_WIDTH-1:0] run_max;
   logic [31:0]           run_idx;
   logic [15:0]           run_cnt;
   logic                  run_err;
   logic [31:0]           word_cnt;

   // Running values with the current beat folded in.
   logic [ELEM_WIDTH-1:0] b_max;
   logic [31:0]           b_idx;
   logic [15:0]           b_cnt;
   logic                  b_err;
   logic [KW-1:0]         kept_n;
   logic [16:0]           cnt_sum;
   logic [63:0]           word_base;
   logic [63:0]           pos;
   logic [ELEM_WIDTH-1:0] lane;

   assign run = (state == S_RUN);

`ifdef ARGMAX_PASSTHRU_EN
   assign S_AXIS_TREADY = run & M_AXIS_TREADY;
   assign M_AXIS_TVALID = S_AXIS_TVALID & run;
   assign M_AXIS_TDATA  = S_AXIS_TDATA;
   assign M_AXIS_TKEEP  = S_AXIS_TKEEP;
   assign M_AXIS_TUSER  = S_AXIS_TUSER;
   assign M_AXIS_TLAST  = S_AXIS_TLAST;
`else
   assign S_AXIS_TREADY = run;
   // TUSER carries nothing this block needs when the stream terminates here.
   logic unused_tuser;
   assign unused_tuser = S_AXIS_TUSER;
`endif

   assign accept = S_AXIS_TVALID & S_AXIS_TREADY;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      argmax_done = 1'b0;
      case (state)
         S_IDLE: if (argmax_start) state_nxt = S_RUN;
         S_RUN: begin
            // Dropping start aborts the frame even if a beat lands this cycle.
            if (!argmax_start)               state_nxt = S_IDLE;
            else if (accept && S_AXIS_TLAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            argmax_done = 1'b1;
            // Must see start low before another run can begin.
            if (!argmax_start) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- beat resolve ----------------
   // Lanes are folded in ascending order; strict '>' keeps the first occurrence on ties.
   always_comb begin
      b_max     = run_max;
      b_idx     = run_idx;
      b_err     = run_err;
      kept_n    = '0;
      pos       = '0;
      lane      = '0;
      word_base = 64'(word_cnt) * 64'(LANES);
      for (int i = 0; i < LANES; i++) begin
         lane = S_AXIS_TDATA[i*ELEM_WIDTH +: ELEM_WIDTH];
         pos  = word_base + 64'(i);
         if (S_AXIS_TKEEP[i*KEEP_STRIDE]) begin
            kept_n = kept_n + KW'(1);
            if (pos < 64'(MAX_CLASSES)) begin
               if ($signed(lane) > $signed(b_max)) begin
                  b_max = lane;
                  b_idx = pos[31:0];
               end
            end else begin
               b_err = 1'b1;
            end
         end
      end
      cnt_sum = {1'b0, run_cnt} + 17'(kept_n);
      b_cnt   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   // ---------------- running state ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_max  <= '0;
         run_idx  <= '0;
         run_cnt  <= '0;
         run_err  <= 1'b0;
         word_cnt <= '0;
      end else if (state == S_IDLE && argmax_start) begin
         run_max  <= MOST_NEG;
         run_idx  <= 32'hFFFF_FFFF;
         run_cnt  <= '0;
         run_err  <= 1'b0;
         word_cnt <= '0;
      end else if (run && accept) begin
         run_max  <= b_max;
         run_idx  <= b_idx;
         run_cnt  <= b_cnt;
         run_err  <= b_err;
         // Saturate so an absurdly long frame keeps landing beyond MAX_CLASSES.
         if (word_cnt != 32'hFFFF_FFFF) word_cnt <= word_cnt + 32'd1;
      end
   end

   // ---------------- result registers ----------------
   // Only a completed frame updates these; aborts and RUN entry leave them alone.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         max_index    <= '0;
         max_value    <= '0;
         elem_count   <= '0;
         overflow_err <= 1'b0;
      end else if (run && accept && S_AXIS_TLAST && argmax_start) begin
         max_index    <= b_idx;
         max_value    <= b_max;
         elem_count   <= b_cnt;
         overflow_err <= b_err;
      end
   end

endmodule

// File: tb/tb_fc_argmax.sv
module tb_fc_argmax;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic        done;
   logic        s_tready;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tuser;
   logic        tlast;
   logic        tvalid;
   logic [31:0] max_index;
   logic [7:0]  max_value;
   logic [15:0] elem_count;
   logic        overflow_err;
`ifdef ARGMAX_PASSTHRU_EN
   logic        m_tready;
   logic        m_tvalid;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tuser;
   logic        m_tlast;
   logic [36:0] mq[$];
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fc_argmax dut (
      .clk           (clk),
      .rstn          (rstn),
      .argmax_start  (start),
      .argmax_done   (done),
      .S_AXIS_TREADY (s_tready),
      .S_AXIS_TDATA  (tdata),
      .S_AXIS_TKEEP  (tkeep),
      .S_AXIS_TUSER  (tuser),
      .S_AXIS_TLAST  (tlast),
      .S_AXIS_TVALID (tvalid),
      .max_index     (max_index),
      .max_value     (max_value),
      .elem_count    (elem_count),
      .overflow_err  (overflow_err)
`ifdef ARGMAX_PASSTHRU_EN
      ,
      .M_AXIS_TREADY (m_tready),
      .M_AXIS_TVALID (m_tvalid),
      .M_AXIS_TDATA  (m_tdata),
      .M_AXIS_TKEEP  (m_tkeep),
      .M_AXIS_TUSER  (m_tuser),
      .M_AXIS_TLAST  (m_tlast)
`endif
   );

`ifdef ARGMAX_PASSTHRU_EN
   always @(posedge clk) begin
      if (m_tvalid && m_tready) mq.push_back({m_tlast, m_tkeep, m_tdata});
   end
`endif

   typedef struct {
      int               nbeats;
      logic [4:0][31:0] dat;
      logic [4:0][3:0]  keep;
      logic [31:0]      exp_idx;
      logic [7:0]       exp_val;
      logic [15:0]      exp_cnt;
      logic             exp_err;
   } vec_t;

   localparam int NV = 9;
   vec_t tbl[NV];

   function automatic vec_t mk(input int nb, input logic [159:0] d, input logic [19:0] k,
                               input logic [31:0] ei, input logic [7:0] ev,
                               input logic [15:0] ec, input logic ee);
      vec_t v;
      v.nbeats  = nb;
      v.dat     = d;
      v.keep    = k;
      v.exp_idx = ei;
      v.exp_val = ev;
      v.exp_cnt = ec;
      v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Presents one beat from the falling edge and holds it until it is taken at a rising edge.
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last, input bit pt);
      int guard;
      guard = 0;
      @(negedge clk);
      tdata  = d;
      tkeep  = k;
      tlast  = last;
      tvalid = 1'b1;
      while (1) begin
`ifdef ARGMAX_PASSTHRU_EN
         m_tready = pt ? ~m_tready : 1'b1;
         #1;
         if (!m_tready) chk("tready_gated", s_tready, 0);
`else
         #1;
`endif
         if (s_tready) break;
         guard++;
         if (guard > 40) begin
            n_vec++;
            n_bad++;
            $display("FAIL tready_timeout: tready stuck at %0b, required 1", s_tready);
            break;
         end
         @(negedge clk);
      end
      if (last) chk("done_before_last", done, 0);
      @(posedge clk);
   endtask

   task automatic run_frame(input vec_t v, input bit pt, input int hold);
      @(negedge clk);
      start = 1'b1;
      for (int b = 0; b < v.nbeats; b++)
         send_beat(v.dat[b], v.keep[b], (b == v.nbeats - 1), pt);
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      chk("done_after_last", done, 1);
      chk("tready_in_done", s_tready, 0);
      chk("max_index", max_index, v.exp_idx);
      chk("max_value", max_value, v.exp_val);
      chk("elem_count", elem_count, v.exp_cnt);
      chk("overflow_err", overflow_err, v.exp_err);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("done_held", done, 1);
         chk("tready_held", s_tready, 0);
      end
      start = 1'b0;
      @(negedge clk);
      chk("done_cleared", done, 0);
      chk("index_kept", max_index, v.exp_idx);
   endtask

   vec_t empty_v;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = mk(1, {128'h0, 32'h057F0280}, 20'h0000F, 32'd2, 8'h7F, 16'd4, 1'b0);
      tbl[1] = mk(4, {32'h0, 32'hFDFD28FD, 32'hFDFDFDFD, 32'hFDFDFDFD, 32'hFDFDFDFD},
                  20'h0FFFF, 32'd13, 8'h28, 16'd16, 1'b0);
      tbl[2] = mk(2, {96'h0, 32'h00090000, 32'h00000900}, 20'h000FF, 32'd1, 8'h09, 16'd8, 1'b0);
      tbl[3] = mk(5, {32'h00640000, 32'h0, 32'h0, 32'h00000032, 32'h0},
                  20'hFFFFF, 32'd4, 8'h32, 16'd20, 1'b1);
      tbl[4] = mk(1, {128'h0, 32'h2070107F}, 20'h0000A, 32'd3, 8'h20, 16'd2, 1'b0);
      tbl[5] = mk(1, {128'h0, 32'h80808080}, 20'h0000F, 32'hFFFF_FFFF, 8'h80, 16'd4, 1'b0);
      tbl[6] = mk(1, {128'h0, 32'hFEFFFDFC}, 20'h0000F, 32'd2, 8'hFF, 16'd4, 1'b0);
      tbl[7] = mk(2, {96'h0, 32'h01020304, 32'h7F7F7F7F}, 20'h000F0, 32'd4, 8'h04, 16'd4, 1'b0);
      tbl[8] = mk(4, {32'h0, 32'h11000000, 32'h0, 32'h0, 32'h0},
                  20'h0FFFF, 32'd15, 8'h11, 16'd16, 1'b0);
      empty_v = mk(1, 160'h0, 20'h00000, 32'hFFFF_FFFF, 8'h80, 16'd0, 1'b0);

      rstn   = 1'b0;
      start  = 1'b0;
      tdata  = '0;
      tkeep  = '0;
      tuser  = 1'b0;
      tlast  = 1'b0;
      tvalid = 1'b0;
`ifdef ARGMAX_PASSTHRU_EN
      m_tready = 1'b1;
`endif
      repeat (2) @(negedge clk);
      chk("rst_done", done, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_index", max_index, 0);
      chk("rst_value", max_value, 0);
      chk("rst_count", elem_count, 0);
      chk("rst_err", overflow_err, 0);
      rstn = 1'b1;

      // Beat offered while idle must not be taken.
      @(negedge clk);
      tvalid = 1'b1;
      tlast  = 1'b1;
      tkeep  = 4'hF;
      #1;
      chk("idle_tready", s_tready, 0);
      @(negedge clk);
      chk("idle_no_done", done, 0);
      tvalid = 1'b0;
      tlast  = 1'b0;

      for (int i = 0; i < NV; i++) run_frame(tbl[i], 1'b0, (i == 0) ? 3 : 0);

      // Abort after two of four beats; previous results must survive.
      @(negedge clk);
      start = 1'b1;
      send_beat(tbl[1].dat[0], tbl[1].keep[0], 1'b0, 1'b0);
      send_beat(tbl[1].dat[1], tbl[1].keep[1], 1'b0, 1'b0);
      @(negedge clk);
      tvalid = 1'b0;
      start  = 1'b0;
      @(negedge clk);
      chk("abort_tready", s_tready, 0);
      chk("abort_done", done, 0);
      chk("abort_index", max_index, tbl[NV-1].exp_idx);
      chk("abort_value", max_value, tbl[NV-1].exp_val);
      chk("abort_count", elem_count, tbl[NV-1].exp_cnt);
      run_frame(empty_v, 1'b0, 0);

      // Reset in the middle of a frame.
      @(negedge clk);
      start = 1'b1;
      send_beat(tbl[0].dat[0], tbl[0].keep[0], 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrst_tready", s_tready, 0);
      chk("midrst_index", max_index, 0);
      chk("midrst_value", max_value, 0);
      chk("midrst_count", elem_count, 0);
      tvalid = 1'b0;
      start  = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      run_frame(tbl[0], 1'b0, 0);

`ifdef ARGMAX_PASSTHRU_EN
      mq.delete();
      run_frame(tbl[1], 1'b1, 0);
      chk("pt_beats", mq.size(), tbl[1].nbeats);
      for (int b = 0; b < mq.size() && b < tbl[1].nbeats; b++)
         chk("pt_beat", mq[b], {(b == tbl[1].nbeats - 1), tbl[1].keep[b], tbl[1].dat[b]});
      m_tready = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fc_argmax.md
Name: fc_argmax

Overview:
- Streaming consumer placed directly downstream of the FC stage's AXIS master output.
- Receives the FC output logits as packed signed 8-bit lanes and tracks the running maximum and its class index.
- On the frame's TLAST it exposes max_index, max_value and element count to the APB register block, with a done handshake matching the FC start/done scheme.

Parameters:
- DATA_WIDTH, 32, AXIS data width; must be a multiple of ELEM_WIDTH.
- ELEM_WIDTH, 8, signed logit width; LANES = DATA_WIDTH/ELEM_WIDTH.
- MAX_CLASSES, 16, highest legal positional index is MAX_CLASSES-1.

Ports:
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- argmax_start  in  1  level from APB; run request
- argmax_done  out  1  result valid; held until argmax_start drops
- S_AXIS_TREADY  out  1  stream ready
- S_AXIS_TDATA  in  DATA_WIDTH  packed logits; lane 0 = bits [ELEM_WIDTH-1:0], lowest index
- S_AXIS_TKEEP  in  DATA_WIDTH/8  lane-valid bits, one per byte lane (ELEM_WIDTH=8)
- S_AXIS_TUSER  in  1  ignored
- S_AXIS_TLAST  in  1  final beat of frame
- S_AXIS_TVALID  in  1  stream valid
- max_index  out  32  argmax result
- max_value  out  ELEM_WIDTH  signed maximum logit
- elem_count  out  16  number of kept lanes in frame
- overflow_err  out  1  a kept lane had index >= MAX_CLASSES
- M_AXIS_TREADY/TVALID/TDATA/TKEEP/TUSER/TLAST  in/out  as S side  present only with ARGMAX_PASSTHRU_EN

Behaviour:
- Reset (rstn=0, async): state IDLE; argmax_done, S_AXIS_TREADY, overflow_err = 0; max_index, max_value, elem_count = 0; word counter = 0.
- FSM IDLE -> RUN when argmax_start=1. On entry, clear running max to most-negative (-128), running index to 32'hFFFF_FFFF, count/err/word counter to 0.
- RUN: S_AXIS_TREADY=1 (combinational from state). A beat is accepted when TVALID&TREADY.
- Per accepted beat, each lane i with TKEEP[i]=1 has positional index = word_cnt*LANES+i.
  - Index < MAX_CLASSES: lane competes.
  - Index >= MAX_CLASSES: lane is ignored and overflow_err is set sticky.
- Compare is signed and strictly greater, so ties keep the lower index (first occurrence). Lanes are resolved in order 0..LANES-1 within the beat, and the beat result is merged against the running max in the same cycle.
- elem_count increments by the number of kept lanes and saturates at 16'hFFFF. word_cnt increments per accepted beat.
- Accepted beat with TLAST=1: RUN -> DONE next cycle.
  - TREADY drops in that cycle.
  - max_index, max_value, elem_count and overflow_err are registered from the final-inclusive running values.
  - argmax_done=1 in that same cycle, i.e. 1 cycle after the TLAST handshake.
- DONE: TREADY=0; outputs held. argmax_start=0 -> IDLE with argmax_done=0 next cycle; result outputs keep their values until the next RUN entry.
- Empty frame (TLAST beat and no lane ever competed): max_index = 32'hFFFF_FFFF, max_value = -128, elem_count = count of kept lanes (may be 0).
- TKEEP=0 beat: consumes a word position (word_cnt advances), no compare, no count.
- argmax_start dropped during RUN: abort to IDLE next cycle, TREADY=0, argmax_done stays 0, result outputs unchanged from the previous frame.
- argmax_start held high after DONE: no re-arm until it is deasserted for at least one cycle.
- Beats presented in IDLE/DONE are not accepted (TREADY=0).
- rstn asserted mid-frame: immediate return to reset values.

Optional Feature:
- Macro ARGMAX_PASSTHRU_EN.
- Defined:
  - M_AXIS ports exist. Each beat is forwarded unchanged: M_TDATA/TKEEP/TUSER/TLAST = S side; M_TVALID = S_TVALID & RUN.
  - S_AXIS_TREADY = M_AXIS_TREADY & RUN. Acceptance and argmax update occur only on the joint handshake.
  - Downstream backpressure stalls the stream with no loss or duplication.
- Undefined: no M_AXIS ports; the stream terminates here and TREADY follows RUN only.

Test Plan:
- Single beat: TDATA=32'h05_7F_02_80, TKEEP=4'hF, TLAST=1 -> max_index=2, max_value=127, elem_count=4, done 1 cycle after the handshake, overflow_err=0.
- Four-beat frame of 16 logits, all -3 except index 13 = 40 -> max_index=13, max_value=40, elem_count=16.
- Tie: index 1=9 and index 6=9, all others 0, two beats -> max_index=1.
- Five beats (20 lanes), index 18 = 100 and max of the first 16 = 50 at index 4 -> max_index=4, overflow_err=1, elem_count=20.
- Abort: start dropped after beat 2 of 4 -> IDLE, done=0, results unchanged. Restarting and sending one beat TKEEP=0 with TLAST -> max_index=32'hFFFF_FFFF, max_value=-128, elem_count=0.
- ARGMAX_PASSTHRU_EN: M_AXIS_TREADY toggled 1010… over a 4-beat frame -> M side sees the identical 4 beats in order, result as without stalls, S_AXIS_TREADY=0 whenever M_AXIS_TREADY=0.
